// File: rtl/modular_invertor_arbiter.sv
// Round-robin share of one modular_invertor core between two word-serial requesters.
// Latency: req ena -> core_ena 2 cycles; reqN_ena is ignored while reqN_rdy=0 (no queueing beyond one pend bit).
module modular_invertor_arbiter #(
    parameter int WORD_WIDTH        = 32,
    parameter int OPERAND_ADDR_BITS = 3,
    parameter int TIMEOUT_CYCLES    = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req0_ena,
    output logic                         req0_rdy,
    output logic                         req0_err,
    output logic [OPERAND_ADDR_BITS-1:0] req0_a_addr,
    input  logic [WORD_WIDTH-1:0]        req0_a_din,
    output logic [OPERAND_ADDR_BITS-1:0] req0_a1_addr,
    output logic                         req0_a1_wren,
    output logic [WORD_WIDTH-1:0]        req0_a1_dout,
    input  logic                         req1_ena,
    output logic                         req1_rdy,
    output logic                         req1_err,
    output logic [OPERAND_ADDR_BITS-1:0] req1_a_addr,
    input  logic [WORD_WIDTH-1:0]        req1_a_din,
    output logic [OPERAND_ADDR_BITS-1:0] req1_a1_addr,
    output logic                         req1_a1_wren,
    output logic [WORD_WIDTH-1:0]        req1_a1_dout,
    output logic                         core_ena,
    input  logic                         core_rdy,
    input  logic [OPERAND_ADDR_BITS-1:0] core_a_addr,
    output logic [WORD_WIDTH-1:0]        core_a_din,
    input  logic [OPERAND_ADDR_BITS-1:0] core_a1_addr,
    input  logic                         core_a1_wren,
    input  logic [WORD_WIDTH-1:0]        core_a1_dout,
    output logic                         owner,
    output logic                         busy
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      pend_q, pend_d;
    logic [1:0]      err_q, err_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q, owner_d;
    logic            busy_q, busy_d;
    logic            core_ena_q, core_ena_d;
    logic [WD_W-1:0] wdog_q, wdog_d;

    logic [1:0]      acc;
    logic [1:0]      pend_nx;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        busy_d       = busy_q;
        core_ena_d   = 1'b0;
        wdog_d       = wdog_q;

        acc     = {req1_ena & ~pend_q[1], req0_ena & ~pend_q[0]};
        pend_nx = pend_q | acc;
        pend_d  = pend_nx;
        err_d   = err_q & ~acc;

        case (state_q)
            S_IDLE: begin
                // A request accepted this cycle can be granted this cycle.
                if (pend_nx != 2'b00) begin
                    owner_d = (pend_nx == 2'b11) ? ~last_grant_q : pend_nx[1];
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                core_ena_d = 1'b1;
                wdog_d     = '0;
                state_d    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY, S_WAIT_DONE: begin
                if (wdog_q == WD_MAX) begin
                    err_d[owner_q] = 1'b1;
                    state_d        = S_RELEASE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                    if (state_q == S_WAIT_BUSY && !core_rdy) begin
                        state_d = S_WAIT_DONE;
                    end else if (state_q == S_WAIT_DONE && core_rdy) begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                pend_d[owner_q] = 1'b0;
                last_grant_d    = owner_q;
                busy_d          = 1'b0;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pend_q       <= 2'b00;
            err_q        <= 2'b00;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            busy_q       <= 1'b0;
            core_ena_q   <= 1'b0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            core_ena_q   <= core_ena_d;
            wdog_q       <= wdog_d;
        end
    end

    logic sel0, sel1;

    always_comb begin
        sel0 = busy_q & ~owner_q;
        sel1 = busy_q & owner_q;

        core_a_din   = sel1 ? req1_a_din : (sel0 ? req0_a_din : '0);

        req0_a_addr  = sel0 ? core_a_addr  : '0;
        req0_a1_addr = sel0 ? core_a1_addr : '0;
        req0_a1_dout = sel0 ? core_a1_dout : '0;
        req0_a1_wren = sel0 & core_a1_wren;

        req1_a_addr  = sel1 ? core_a_addr  : '0;
        req1_a1_addr = sel1 ? core_a1_addr : '0;
        req1_a1_dout = sel1 ? core_a1_dout : '0;
        req1_a1_wren = sel1 & core_a1_wren;
    end

    assign req0_rdy = ~pend_q[0];
    assign req1_rdy = ~pend_q[1];
    assign req0_err = err_q[0];
    assign req1_err = err_q[1];
    assign core_ena = core_ena_q;
    assign owner    = owner_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_modular_invertor_arbiter.sv
// Bench for modular_invertor_arbiter: stub core computes word[i] -> ~word[i] + i through the arbiter's routing.
// Grant order and result banks are predicted by a round-robin scoreboard in the bench.
module tb_modular_invertor_arbiter;

    localparam int W  = 32;
    localparam int AB = 3;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_ena = 1'b0, req1_ena = 1'b0;
    logic          req0_rdy, req1_rdy, req0_err, req1_err;
    logic [AB-1:0] req0_a_addr, req1_a_addr, req0_a1_addr, req1_a1_addr;
    logic [W-1:0]  req0_a_din, req1_a_din, req0_a1_dout, req1_a1_dout;
    logic          req0_a1_wren, req1_a1_wren;
    logic          core_ena, core_rdy, core_a1_wren;
    logic [AB-1:0] core_a_addr, core_a1_addr;
    logic [W-1:0]  core_a_din, core_a1_dout;
    logic          owner, busy;

    always #5 clk = ~clk;

    modular_invertor_arbiter #(.WORD_WIDTH(W), .OPERAND_ADDR_BITS(AB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_ena(req0_ena), .req0_rdy(req0_rdy), .req0_err(req0_err),
        .req0_a_addr(req0_a_addr), .req0_a_din(req0_a_din),
        .req0_a1_addr(req0_a1_addr), .req0_a1_wren(req0_a1_wren), .req0_a1_dout(req0_a1_dout),
        .req1_ena(req1_ena), .req1_rdy(req1_rdy), .req1_err(req1_err),
        .req1_a_addr(req1_a_addr), .req1_a_din(req1_a_din),
        .req1_a1_addr(req1_a1_addr), .req1_a1_wren(req1_a1_wren), .req1_a1_dout(req1_a1_dout),
        .core_ena(core_ena), .core_rdy(core_rdy),
        .core_a_addr(core_a_addr), .core_a_din(core_a_din),
        .core_a1_addr(core_a1_addr), .core_a1_wren(core_a1_wren), .core_a1_dout(core_a1_dout),
        .owner(owner), .busy(busy)
    );

    // Requester banks: A is 1-cycle-latency BRAM, A1 captures writes.
    logic [W-1:0] a_bank  [2][8];
    logic [W-1:0] a1_bank [2][8];
    logic         clr_a1 = 1'b0;

    always @(posedge clk) begin
        req0_a_din <= a_bank[0][req0_a_addr];
        req1_a_din <= a_bank[1][req1_a_addr];
        if (clr_a1) begin
            for (int i = 0; i < 8; i++) begin
                a1_bank[0][i] <= '0;
                a1_bank[1][i] <= '0;
            end
        end else begin
            if (req0_a1_wren) a1_bank[0][req0_a1_addr] <= req0_a1_dout;
            if (req1_a1_wren) a1_bank[1][req1_a1_addr] <= req1_a1_dout;
        end
    end

    // Stub core: reads A words 0..7 and writes ~A[i]+i one cycle later; stuck=1 never leaves rdy.
    logic       stuck = 1'b0;
    logic       run;
    logic [3:0] cnt;
    logic [3:0] widx;

    always @(posedge clk) begin
        if (rst) begin
            run      <= 1'b0;
            core_rdy <= 1'b1;
            cnt      <= '0;
        end else if (core_ena && !stuck && !run) begin
            run      <= 1'b1;
            core_rdy <= 1'b0;
            cnt      <= '0;
        end else if (run) begin
            if (cnt == 4'd9) begin
                run      <= 1'b0;
                core_rdy <= 1'b1;
            end
            cnt <= cnt + 4'd1;
        end
    end

    assign widx         = cnt - 4'd1;
    assign core_a_addr  = (run && cnt < 4'd8) ? cnt[2:0] : '0;
    assign core_a1_wren = run && cnt >= 4'd1 && cnt <= 4'd8;
    assign core_a1_addr = widx[2:0];
    assign core_a1_dout = ~core_a_din + {{(W-3){1'b0}}, widx[2:0]};

    // Monitor: grant log and routing invariants.
    logic [0:0] grant_q[$];
    int         ena_cnt = 0;
    int         viol = 0;
    logic       prev_ena = 1'b0;

    always @(negedge clk) begin
        if (core_ena) begin
            grant_q.push_back(owner);
            ena_cnt++;
        end
        if (core_ena && prev_ena) viol++;
        prev_ena = core_ena;
        if (req0_a1_wren && !(busy && !owner)) viol++;
        if (req1_a1_wren && !(busy && owner)) viol++;
        if (busy && !owner && req1_a_addr != '0) viol++;
        if (busy && owner && req0_a_addr != '0) viol++;
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    logic model_lg;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0_ena = 1'b0; req1_ena = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        grant_q.delete();
        ena_cnt  = 0;
        model_lg = 1'b1;
    endtask

    task automatic prep(input logic f0, input logic f1);
        for (int i = 0; i < 8; i++) begin
            if (f0) a_bank[0][i] = $urandom;
            if (f1) a_bank[1][i] = $urandom;
        end
        clr_a1 = 1'b1;
        @(negedge clk);
        clr_a1 = 1'b0;
        grant_q.delete();
        ena_cnt = 0;
    endtask

    task automatic pulse(input logic e0, input logic e1);
        req0_ena = e0; req1_ena = e1;
        @(negedge clk);
        req0_ena = 1'b0; req1_ena = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (req0_rdy && req1_rdy && !busy) done = 1'b1;
            else @(negedge clk);
        end
        chk(tag, done, 1'b1);
    endtask

    task automatic check_bank(input int n, input string tag);
        logic [W-1:0] e;
        for (int i = 0; i < 8; i++) begin
            e = ~a_bank[n][i] + W'(i);
            chk($sformatf("%s_w%0d", tag, i), a1_bank[n][i], e);
        end
    endtask

    task automatic check_order(input string tag, input logic [0:0] exp_q[$]);
        chk({tag, "_len"}, grant_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < grant_q.size(); i++)
            chk($sformatf("%s_g%0d", tag, i), grant_q[i], exp_q[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [0:0] eq[$];
        int         n;
        logic       ok;

        for (int i = 0; i < 8; i++) begin
            a_bank[0][i] = '0;
            a_bank[1][i] = '0;
        end
        repeat (2) @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_core_ena", core_ena, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_rdy", {req1_rdy, req0_rdy}, 2'b11);
        chk("rst_err", {req1_err, req0_err}, 2'b00);
        chk("rst_wren", {req1_a1_wren, req0_a1_wren}, 2'b00);

        // Single request from requester 0, with start latency
        prep(1, 1);
        req0_ena = 1'b1;
        @(negedge clk);
        req0_ena = 1'b0;
        chk("single_rdy_low", req0_rdy, 0);
        chk("single_ena_early", core_ena, 0);
        chk("single_busy", busy, 1);
        @(negedge clk);
        chk("single_core_ena", core_ena, 1);
        chk("single_owner", owner, 0);
        wait_idle("single_done");
        check_bank(0, "single_r0");
        chk("single_r1_untouched", a1_bank[1][0] | a1_bank[1][7], 0);
        chk("single_err", req0_err, 0);
        chk("single_ena_cnt", ena_cnt, 1);
        model_lg = 1'b0;

        // Simultaneous ena after reset: requester 0 first
        do_reset();
        prep(1, 1);
        pulse(1, 1);
        wait_idle("both_done");
        eq = '{1'b0, 1'b1};
        check_order("both", eq);
        check_bank(0, "both_r0");
        check_bank(1, "both_r1");

        // Round-robin and re-request at RELEASE+1
        do_reset();
        prep(1, 1);
        pulse(0, 1);
        wait_idle("rr_first");
        pulse(1, 1);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (busy && owner) ok = 1'b1;
            else @(negedge clk);
        end
        chk("rr_r1_running", ok, 1);
        pulse(1, 0);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (req1_rdy) ok = 1'b1;
            else @(negedge clk);
        end
        chk("rr_r1_release", ok, 1);
        pulse(0, 1);
        wait_idle("rr_done");
        eq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        check_order("rr", eq);
        check_bank(0, "rr_r0");
        check_bank(1, "rr_r1");

        // Ignored ena from the owner while busy
        do_reset();
        prep(1, 0);
        pulse(1, 0);
        repeat (3) @(negedge clk);
        pulse(1, 0);
        repeat (4) @(negedge clk);
        pulse(1, 0);
        wait_idle("ign_done");
        repeat (5) @(negedge clk);
        chk("ign_ena_cnt", ena_cnt, 1);
        chk("ign_rdy", req0_rdy, 1);
        check_bank(0, "ign_r0");

        // Watchdog: core never drops rdy
        do_reset();
        stuck = 1'b1;
        prep(0, 0);
        pulse(1, 0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (core_ena) ok = 1'b1;
            else @(negedge clk);
        end
        chk("to_core_ena", ok, 1);
        n = 0;
        while (!req0_rdy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", n, 18);
        chk("to_err0", req0_err, 1);
        chk("to_err1", req1_err, 0);
        chk("to_busy", busy, 0);
        stuck = 1'b0;
        prep(1, 0);
        pulse(1, 0);
        chk("to_err_cleared", req0_err, 0);
        wait_idle("to_retry_done");
        check_bank(0, "to_retry_r0");
        chk("to_retry_err", req0_err, 0);

        // Reset during WAIT_DONE
        do_reset();
        prep(1, 0);
        pulse(1, 0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (busy && !core_rdy) ok = 1'b1;
            else @(negedge clk);
        end
        chk("mid_running", ok, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_rdy", {req1_rdy, req0_rdy}, 2'b11);
        chk("mid_core_ena", core_ena, 0);
        model_lg = 1'b1;
        prep(1, 0);
        pulse(1, 0);
        wait_idle("mid_after_done");
        check_bank(0, "mid_after_r0");

        // Randomized request patterns against the round-robin scoreboard
        model_lg = 1'b1;
        for (int it = 0; it < 24; it++) begin
            int   mode, d;
            logic first;
            mode  = $urandom_range(0, 2);
            d     = (mode == 2) ? $urandom_range(0, 2) : 0;
            first = 1'($urandom_range(0, 1));
            prep(mode != 1, mode != 0);
            eq.delete();
            if (mode == 0) begin
                pulse(1, 0);
                eq.push_back(1'b0);
            end else if (mode == 1) begin
                pulse(0, 1);
                eq.push_back(1'b1);
            end else if (d == 0) begin
                pulse(1, 1);
                eq.push_back(~model_lg);
                eq.push_back(model_lg);
            end else begin
                pulse(~first, first);
                repeat (d - 1) @(negedge clk);
                pulse(first, ~first);
                eq.push_back(first);
                eq.push_back(~first);
            end
            model_lg = eq[eq.size() - 1];
            wait_idle($sformatf("rnd%0d_done", it));
            check_order($sformatf("rnd%0d", it), eq);
            if (mode != 1) check_bank(0, $sformatf("rnd%0d_r0", it));
            if (mode != 0) check_bank(1, $sformatf("rnd%0d_r1", it));
        end

        chk("routing_invariants", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
